// File: rtl/hdr_ddr_cmd_scheduler_if.sv
// Host-side bundle for hdr_ddr_cmd_scheduler: descriptor push handshake and response handshake.
// Signal names are kept from the scheduler's point of view (i_ = into the scheduler).
interface hdr_ddr_cmd_scheduler_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [31:0] i_cmd_desc;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [15:0] o_resp_data;

  modport master (
    output i_cmd_valid,
    output i_cmd_desc,
    output i_resp_ready,
    input  o_cmd_ready,
    input  o_resp_valid,
    input  o_resp_data
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_desc,
    input  i_resp_ready,
    output o_cmd_ready,
    output o_resp_valid,
    output o_resp_data
  );
endinterface

// File: rtl/hdr_ddr_cmd_scheduler.sv
// Command FIFO plus one-at-a-time issue FSM in front of the HDR-DDR engine, with retry, back-off and timeout.
// Optional macro HDR_SCHED_FLUSH_EN adds i_flush, which empties the FIFO without touching the in-flight command.
module hdr_ddr_cmd_scheduler #(
  parameter int CMDQ_DEPTH     = 4,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
`ifdef HDR_SCHED_FLUSH_EN
  input  logic                   i_flush,
`endif
  hdr_ddr_cmd_scheduler_if.slave io_host,
  output logic                   o_engine_en,
  output logic [4:0]             o_regf_dev_index,
  output logic                   o_regf_wr_rd_bit,
  output logic                   o_regf_toc,
  output logic                   o_regf_short_read,
  output logic                   o_regf_wroc,
  output logic                   o_regf_cmd_attr,
  output logic [2:0]             o_regf_dtt,
  output logic [15:0]            o_regf_DATA_LEN,
  input  logic                   i_engine_done,
  input  logic                   i_regf_abort,
  input  logic [3:0]             i_regf_error_type,
  output logic                   o_busy
);

  localparam int PTR_W = (CMDQ_DEPTH > 1) ? $clog2(CMDQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1) + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(CMDQ_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BO_W-1:0]  BO_LAST    = BO_W'(BACKOFF_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);
  localparam logic [3:0]       ERR_FATAL  = 4'hF;
  localparam logic [3:0]       ERR_TMO    = 4'hE;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // Command FIFO
  logic [31:0]      r_mem [CMDQ_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_cmd_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;

  // Issue FSM
  logic [2:0]       r_state;
  logic [31:0]      r_cur_desc;
  logic             r_engine_en;
  logic [TMO_W-1:0] r_tmo;
  logic [BO_W-1:0]  r_bo;
  logic [1:0]       r_retries;
  logic             r_resp_valid;
  logic [3:0]       r_resp_err;
  logic             r_resp_aborted;
  logic             r_resp_timeout;

`ifdef HDR_SCHED_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_push = io_host.i_cmd_valid & r_cmd_ready & ~w_flush;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_host.i_cmd_desc;
    end
  end

  // Ready is registered from the next occupancy, so it is exactly !full in every cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_cmd_ready <= (w_count_next != FIFO_FULL);
      if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state        <= S_IDLE;
      r_cur_desc     <= '0;
      r_engine_en    <= 1'b0;
      r_tmo          <= '0;
      r_bo           <= '0;
      r_retries      <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_err     <= '0;
      r_resp_aborted <= 1'b0;
      r_resp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_desc <= r_mem[r_rd_ptr];
            r_retries  <= '0;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_tmo       <= '0;
          r_engine_en <= 1'b1;
          r_state     <= S_RUN;
        end

        S_RUN: begin
          if (i_engine_done) begin
            r_engine_en    <= 1'b0;
            r_resp_err     <= '0;
            r_resp_aborted <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else if (i_regf_abort && (i_regf_error_type != ERR_FATAL) && (r_retries < RETRY_MAX)) begin
            r_engine_en <= 1'b0;
            r_retries   <= r_retries + 1'b1;
            r_bo        <= BO_W'(1);
            r_state     <= S_BACKOFF;
          end else if (i_regf_abort) begin
            r_engine_en    <= 1'b0;
            r_resp_err     <= i_regf_error_type;
            r_resp_aborted <= 1'b1;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else if (r_tmo == TMO_LAST) begin
            r_engine_en    <= 1'b0;
            r_resp_err     <= ERR_TMO;
            r_resp_aborted <= 1'b0;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        // The LOAD cycle is the last idle cycle of the gap, so BACKOFF itself lasts BACKOFF_CYCLES-1.
        S_BACKOFF: begin
          if (r_bo >= BO_LAST) begin
            r_state <= S_LOAD;
          end else begin
            r_bo <= r_bo + 1'b1;
          end
        end

        S_RESP: begin
          if (io_host.i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_engine_en  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign io_host.o_cmd_ready  = r_cmd_ready;
  assign io_host.o_resp_valid = r_resp_valid;
  assign io_host.o_resp_data  = {r_cur_desc[4:0], r_retries, r_resp_timeout,
                                 r_resp_aborted, r_resp_err, r_cur_desc[31:29]};

  assign o_engine_en       = r_engine_en;
  assign o_regf_dev_index  = r_cur_desc[4:0];
  assign o_regf_wr_rd_bit  = r_cur_desc[5];
  assign o_regf_toc        = r_cur_desc[6];
  assign o_regf_short_read = r_cur_desc[7];
  assign o_regf_wroc       = r_cur_desc[8];
  assign o_regf_cmd_attr   = r_cur_desc[9];
  assign o_regf_dtt        = r_cur_desc[12:10];
  assign o_regf_DATA_LEN   = r_cur_desc[28:13];

  assign o_busy = (r_count != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_hdr_ddr_cmd_scheduler.sv
// Randomized bench for hdr_ddr_cmd_scheduler: a transaction-level model predicts every response word,
// enable timing, back-off gap, timeout length and FIFO acceptance.
module tb_hdr_ddr_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int MAXR  = 2;
  localparam int TMO   = 64;
  localparam int BO    = 8;

  // A command plus the engine behaviour planned for it: n_ab retryable aborts, then a final outcome
  // (0 done, 1 fatal abort, 2 silent -> timeout, 3 done and abort together).
  typedef struct {
    logic [31:0] desc;
    int          n_ab;
    logic [3:0]  ab_err;
    int          fin;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  etype = 4'h0;
`ifdef HDR_SCHED_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic        o_engine_en;
  logic [4:0]  o_regf_dev_index;
  logic        o_regf_wr_rd_bit;
  logic        o_regf_toc;
  logic        o_regf_short_read;
  logic        o_regf_wroc;
  logic        o_regf_cmd_attr;
  logic [2:0]  o_regf_dtt;
  logic [15:0] o_regf_DATA_LEN;
  logic        o_busy;

  hdr_ddr_cmd_scheduler_if host();

  hdr_ddr_cmd_scheduler #(
    .CMDQ_DEPTH    (DEPTH),
    .MAX_RETRY     (MAXR),
    .TIMEOUT_CYCLES(TMO),
    .BACKOFF_CYCLES(BO)
  ) dut (
    .i_sys_clk        (clk),
    .i_sys_rst        (rst),
`ifdef HDR_SCHED_FLUSH_EN
    .i_flush          (flush),
`endif
    .io_host          (host.slave),
    .o_engine_en      (o_engine_en),
    .o_regf_dev_index (o_regf_dev_index),
    .o_regf_wr_rd_bit (o_regf_wr_rd_bit),
    .o_regf_toc       (o_regf_toc),
    .o_regf_short_read(o_regf_short_read),
    .o_regf_wroc      (o_regf_wroc),
    .o_regf_cmd_attr  (o_regf_cmd_attr),
    .o_regf_dtt       (o_regf_dtt),
    .o_regf_DATA_LEN  (o_regf_DATA_LEN),
    .i_engine_done    (done),
    .i_regf_abort     (abort),
    .i_regf_error_type(etype),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t gen_cmd(input int idx);
    cmd_t c;
    c.desc        = $urandom;
    c.desc[31:29] = 3'(idx);
    c.n_ab        = $urandom_range(0, 3);
    c.ab_err      = 4'($urandom_range(0, 14));
    c.fin         = $urandom_range(0, 3);
    return c;
  endfunction

  // Response word from the command's plan: retries saturate at MAXR, after which the abort is final.
  function automatic logic [15:0] model_resp(input cmd_t c);
    int         retries;
    logic [3:0] err;
    logic       ab;
    logic       to;
    ab = 1'b0;
    to = 1'b0;
    err = 4'h0;
    if (c.n_ab > MAXR) begin
      retries = MAXR;
      err     = c.ab_err;
      ab      = 1'b1;
    end else begin
      retries = c.n_ab;
      if (c.fin == 1) begin
        err = 4'hF;
        ab  = 1'b1;
      end else if (c.fin == 2) begin
        err = 4'hE;
        to  = 1'b1;
      end
    end
    return {c.desc[4:0], 2'(retries), to, ab, err, c.desc[2'd0 +: 0 + 3] & 3'b000 | c.desc[31:29]};
  endfunction

  task automatic fire(input logic d, input logic a, input logic [3:0] e);
    repeat ($urandom_range(0, 8)) step();
    chk("en_hold", 32'(o_engine_en), 32'(1));
    done  = d;
    abort = a;
    etype = e;
    step();
    done  = 1'b0;
    abort = 1'b0;
    etype = 4'h0;
  endtask

  task automatic push(input cmd_t c, input bit exp_acc);
    chk("cmd_ready", 32'(host.o_cmd_ready), 32'(exp_acc));
    host.i_cmd_valid = 1'b1;
    host.i_cmd_desc  = c.desc;
    step();
    host.i_cmd_valid = 1'b0;
  endtask

  // Runs every planned engine attempt of one command and leaves it waiting in the response state.
  task automatic run_cmd(input cmd_t c);
    int          runs;
    int          cnt;
    logic [31:0] d;
    logic [28:0] regf_exp;
    d = c.desc;
    regf_exp = {d[4:0], d[5], d[6], d[7], d[8], d[9], d[12:10], d[28:13]};
    runs = (c.n_ab > MAXR) ? MAXR + 1 : c.n_ab + 1;
    cnt = 0;
    while (!o_engine_en && cnt < 20) begin
      cnt++;
      step();
    end
    chk("issue", 32'(o_engine_en), 32'(1));
    if (!o_engine_en) return;
    for (int r = 0; r < runs; r++) begin
      if (r > 0) begin
        cnt = 0;
        while (!o_engine_en && cnt < 40) begin
          cnt++;
          step();
        end
        chk("backoff_gap", 32'(cnt), 32'(BO));
        if (!o_engine_en) return;
      end
      chk("regf", 32'({o_regf_dev_index, o_regf_wr_rd_bit, o_regf_toc, o_regf_short_read,
                       o_regf_wroc, o_regf_cmd_attr, o_regf_dtt, o_regf_DATA_LEN}), 32'(regf_exp));
      if (r < c.n_ab) begin
        fire(1'b0, 1'b1, c.ab_err);
      end else if (c.fin == 0) begin
        fire(1'b1, 1'b0, 4'h0);
      end else if (c.fin == 1) begin
        fire(1'b0, 1'b1, 4'hF);
      end else if (c.fin == 3) begin
        fire(1'b1, 1'b1, 4'($urandom_range(0, 15)));
      end else begin
        cnt = 0;
        while (o_engine_en && cnt < 200) begin
          cnt++;
          step();
        end
        chk("timeout_len", 32'(cnt), 32'(TMO));
      end
      chk("en_fall", 32'(o_engine_en), 32'(0));
      chk("resp_valid_rise", 32'(host.o_resp_valid), 32'(r == runs - 1));
    end
  endtask

  task automatic take_resp(input cmd_t c);
    logic [15:0] exp;
    int          bp;
    exp = model_resp(c);
    bp  = $urandom_range(0, 10);
    chk("resp_valid", 32'(host.o_resp_valid), 32'(1));
    chk("resp_data", 32'(host.o_resp_data), 32'(exp));
    for (int i = 0; i < bp; i++) begin
      step();
      chk("resp_hold_valid", 32'(host.o_resp_valid), 32'(1));
      chk("resp_hold_data", 32'(host.o_resp_data), 32'(exp));
    end
    $display("resp tid=%0d dev=%0d retries=%0d timeout=%0d aborted=%0d err=%0h bp=%0d",
             exp[2:0], exp[15:11], exp[10:9], exp[8], exp[7], exp[6:3], bp);
    host.i_resp_ready = 1'b1;
    step();
    host.i_resp_ready = 1'b0;
    chk("resp_drop", 32'(host.o_resp_valid), 32'(0));
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t q[$];
    cmd_t held;
    cmd_t c;
    int   idx;
    int   fill;
    int   k;
    int   cnt;
    bit   seen;

    idx = 0;
    host.i_cmd_valid  = 1'b0;
    host.i_cmd_desc   = '0;
    host.i_resp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_en", 32'(o_engine_en), 32'(0));
    chk("rst_resp_valid", 32'(host.o_resp_valid), 32'(0));
    chk("rst_resp_data", 32'(host.o_resp_data), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_regf", 32'({o_regf_dev_index, o_regf_dtt, o_regf_DATA_LEN}), 32'(0));
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(host.o_cmd_ready), 32'(1));

    held = gen_cmd(idx);
    idx++;
    push(held, 1'b1);
    run_cmd(held);

    // Each batch is pushed while the previous command is stalled in the response state, so no pops happen.
    for (int b = 0; b < 10; b++) begin
      k = $urandom_range(1, 6);
      fill = 0;
      q.delete();
      for (int j = 0; j < k; j++) begin
        c = gen_cmd(idx);
        idx++;
        push(c, fill < DEPTH);
        if (fill < DEPTH) begin
          q.push_back(c);
          fill++;
        end
      end
      chk("ready_after_batch", 32'(host.o_cmd_ready), 32'(fill < DEPTH));
      chk("busy_batch", 32'(o_busy), 32'(1));
      take_resp(held);
      for (int i = 0; i < q.size(); i++) begin
        run_cmd(q[i]);
        if (i < q.size() - 1) take_resp(q[i]);
        else held = q[i];
      end
    end
    take_resp(held);
    repeat (3) step();
    chk("idle_busy", 32'(o_busy), 32'(0));

    // Reset in the middle of a run with two more commands queued behind it.
    c = gen_cmd(idx);
    idx++;
    push(c, 1'b1);
    cnt = 0;
    while (!o_engine_en && cnt < 20) begin
      cnt++;
      step();
    end
    chk("pre_rst_issue", 32'(o_engine_en), 32'(1));
    c = gen_cmd(idx);
    idx++;
    push(c, 1'b1);
    c = gen_cmd(idx);
    idx++;
    push(c, 1'b1);
    rst = 1'b1;
    step();
    chk("midrun_rst_en", 32'(o_engine_en), 32'(0));
    chk("midrun_rst_resp_valid", 32'(host.o_resp_valid), 32'(0));
    chk("midrun_rst_busy", 32'(o_busy), 32'(0));
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(host.o_cmd_ready), 32'(1));
    seen = 1'b0;
    repeat (12) begin
      step();
      if (o_engine_en || host.o_resp_valid) seen = 1'b1;
    end
    chk("no_stale_issue", 32'(seen), 32'(0));

    c = gen_cmd(idx);
    idx++;
    push(c, 1'b1);
    run_cmd(c);
    take_resp(c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
